// File: rtl/ahb_apb_timer_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_timer_bridge
//  Purpose  : AHB-Lite slave to APB master bridge for the APB timer. It turns
//             each single word AHB transfer into one APB SETUP/ACCESS pair.
//             PRDATA is returned on HRDATA. PSLVERR, or an illegal size or
//             alignment, produces the two-cycle AHB ERROR response.
//  Ports    : HCLK, HRESETn          - clock, synchronous active-low reset
//             HSEL..HREADY           - AHB-Lite slave address/data inputs
//             HREADYOUT/HRESP/HRDATA - AHB-Lite slave response
//             PADDR..PENABLE         - APB master request outputs
//             PRDATA/PREADY/PSLVERR  - APB completion inputs
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_apb_timer_bridge #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [31:0]               HRDATA,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LATCH  = 3'd1;
    localparam logic [2:0] c_ST_SETUP  = 3'd2;
    localparam logic [2:0] c_ST_ACCESS = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;
    localparam logic [2:0] c_ST_ERR1   = 3'd5;
    localparam logic [2:0] c_ST_ERR2   = 3'd6;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic                      r_pwrite;
    logic [31:0]               r_pwdata;
    logic [31:0]               r_hrdata;

    logic w_capture;
    logic w_legal;
    logic w_can_capture;
    logic w_apb_done;

    // Address bits above the APB window and HTRANS[0] carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, HADDR[31:APB_ADDR_WIDTH], HTRANS[0]};

    assign w_capture     = HSEL & HREADY & HTRANS[1];
    assign w_legal       = (HSIZE == 3'b010) & (HADDR[1:0] == 2'b00);
    // A new address phase may only be accepted in states that drive HREADYOUT=1.
    assign w_can_capture = (r_state == c_ST_IDLE) | (r_state == c_ST_DONE) |
                           (r_state == c_ST_ERR2);
    assign w_apb_done    = (r_state == c_ST_ACCESS) & PREADY;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR2: begin
                if (w_capture) begin
                    w_state_nxt = w_legal ? c_ST_LATCH : c_ST_ERR1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_LATCH:  w_state_nxt = c_ST_SETUP;
            c_ST_SETUP:  w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = PSLVERR ? c_ST_ERR1 : c_ST_DONE;
                end
            end
            c_ST_ERR1:   w_state_nxt = c_ST_ERR2;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state  <= c_ST_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Address and direction only change while no APB access is open,
            // so they stay stable through SETUP and every ACCESS wait cycle.
            if (w_can_capture && w_capture) begin
                r_paddr  <= HADDR[APB_ADDR_WIDTH-1:0];
                r_pwrite <= HWRITE;
            end
            // LATCH is the AHB data phase, the cycle in which HWDATA is valid.
            if ((r_state == c_ST_LATCH) && r_pwrite) begin
                r_pwdata <= HWDATA;
            end
            if (w_apb_done && !PSLVERR && !r_pwrite) begin
                r_hrdata <= PRDATA;
            end
        end
    end

    // Handshake outputs are pure decodes of the state register, so there is
    // no combinational path from PREADY to HREADYOUT.
    assign PSEL      = (r_state == c_ST_SETUP) | (r_state == c_ST_ACCESS);
    assign PENABLE   = (r_state == c_ST_ACCESS);
    assign HREADYOUT = w_can_capture;
    assign HRESP     = (r_state == c_ST_ERR1) | (r_state == c_ST_ERR2);
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign HRDATA    = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_timer_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_apb_timer_bridge
//  Purpose  : Directed self-checking bench for ahb_apb_timer_bridge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_apb_timer_bridge;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    ahb_apb_timer_bridge #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PENABLE must never be high without PSEL, checked every cycle.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1) begin
            total++;
            assert (!(PENABLE === 1'b1 && PSEL !== 1'b1)) else begin
                bad++;
                $error("FAIL penable_without_psel obs psel=%b penable=%b exp no penable without psel",
                       PSEL, PENABLE);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HADDR  = 32'h0;
    endtask

    // Present one address phase and advance through the edge that samples it.
    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
        HREADY = 1'b1;
        tick();
        bus_idle();
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HWDATA  = 32'h0;
        PRDATA  = 32'hDEAD_BEEF;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        bus_idle();
        tick();
        tick();
        HRESETn = 1'b1;

        // ---------------- reset state ----------------
        chk("rst_psel",      {31'b0, PSEL},      32'h0);
        chk("rst_penable",   {31'b0, PENABLE},   32'h0);
        chk("rst_pwrite",    {31'b0, PWRITE},    32'h0);
        chk("rst_paddr",     {20'b0, PADDR},     32'h0);
        chk("rst_pwdata",    PWDATA,             32'h0);
        chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
        chk("rst_hresp",     {31'b0, HRESP},     32'h0);
        chk("rst_hrdata",    HRDATA,             32'h0);

        // ---------------- not-selected / BUSY: no change ----------------
        HSEL = 1'b0; HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b1;
        tick();
        chk("nosel_psel",  {31'b0, PSEL},      32'h0);
        chk("nosel_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        HSEL = 1'b1; HTRANS = 2'b01;
        tick();
        chk("busy_psel",   {31'b0, PSEL},      32'h0);
        chk("busy_hrdy",   {31'b0, HREADYOUT}, 32'h1);
        chk("busy_hresp",  {31'b0, HRESP},     32'h0);
        bus_idle();
        tick();

        // ---------------- zero-wait write 0x10C ----------------
        addr_phase(32'h0000_010C, 1'b1, 3'b010);            // N+1 LATCH
        HWDATA = 32'h0000_0020;
        chk("w1_latch_hrdy", {31'b0, HREADYOUT}, 32'h0);
        chk("w1_latch_psel", {31'b0, PSEL},      32'h0);
        tick();                                              // N+2 SETUP
        HWDATA = 32'h0;
        chk("w1_setup_psel", {31'b0, PSEL},      32'h1);
        chk("w1_setup_pen",  {31'b0, PENABLE},   32'h0);
        chk("w1_paddr",      {20'b0, PADDR},     32'h10C);
        chk("w1_pwdata",     PWDATA,             32'h20);
        chk("w1_pwrite",     {31'b0, PWRITE},    32'h1);
        tick();                                              // N+3 ACCESS
        chk("w1_acc_pen",    {31'b0, PENABLE},   32'h1);
        chk("w1_acc_hrdy",   {31'b0, HREADYOUT}, 32'h0);
        tick();                                              // N+4 DONE
        chk("w1_done_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        chk("w1_done_hresp", {31'b0, HRESP},     32'h0);
        chk("w1_done_psel",  {31'b0, PSEL},      32'h0);
        chk("w1_hrdata_kept", HRDATA,            32'h0);
        tick();

        // ---------------- read 0x100 with 3 wait cycles ----------------
        PREADY = 1'b0;
        PRDATA = 32'h0002_0005;
        addr_phase(32'h0000_0100, 1'b0, 3'b010);            // N+1
        tick();                                              // N+2 SETUP
        chk("r1_setup_psel", {31'b0, PSEL},      32'h1);
        chk("r1_pwrite",     {31'b0, PWRITE},    32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();                                          // N+3..N+6 ACCESS
            chk($sformatf("r1_acc%0d_pen", i),   {31'b0, PENABLE},   32'h1);
            chk($sformatf("r1_acc%0d_paddr", i), {20'b0, PADDR},     32'h100);
            chk($sformatf("r1_acc%0d_hrdy", i),  {31'b0, HREADYOUT}, 32'h0);
        end
        PREADY = 1'b1;                                       // completes at end of N+6
        tick();                                              // N+7 DONE
        chk("r1_done_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        chk("r1_hrdata",     HRDATA,             32'h0002_0005);
        chk("r1_pwdata_kept", PWDATA,            32'h20);
        PRDATA = 32'hCAFE_F00D;
        tick();
        chk("r1_hrdata_hold", HRDATA,            32'h0002_0005);

        // ---------------- write 0x114 with PSLVERR ----------------
        PSLVERR = 1'b1;
        addr_phase(32'h0000_0114, 1'b1, 3'b010);
        HWDATA = 32'h0000_0033;
        tick();                                              // SETUP
        tick();                                              // ACCESS
        chk("e1_acc_pen",   {31'b0, PENABLE},   32'h1);
        tick();                                              // ERR1
        chk("e1_err1_hresp", {31'b0, HRESP},     32'h1);
        chk("e1_err1_hrdy",  {31'b0, HREADYOUT}, 32'h0);
        chk("e1_err1_psel",  {31'b0, PSEL},      32'h0);
        tick();                                              // ERR2
        chk("e1_err2_hresp", {31'b0, HRESP},     32'h1);
        chk("e1_err2_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        chk("e1_err2_psel",  {31'b0, PSEL},      32'h0);
        PSLVERR = 1'b0;
        tick();                                              // IDLE
        chk("e1_idle_hresp", {31'b0, HRESP},     32'h0);
        chk("e1_hrdata_kept", HRDATA,            32'h0002_0005);

        // ---------------- illegal size / alignment ----------------
        addr_phase(32'h0000_0104, 1'b1, 3'b000);            // byte write
        chk("ib_err1_hresp", {31'b0, HRESP},     32'h1);
        chk("ib_err1_hrdy",  {31'b0, HREADYOUT}, 32'h0);
        chk("ib_err1_psel",  {31'b0, PSEL},      32'h0);
        tick();
        chk("ib_err2_hresp", {31'b0, HRESP},     32'h1);
        chk("ib_err2_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        chk("ib_err2_psel",  {31'b0, PSEL},      32'h0);
        tick();
        chk("ib_idle_psel",  {31'b0, PSEL},      32'h0);
        addr_phase(32'h0000_0106, 1'b1, 3'b010);            // misaligned word
        chk("ia_err1_hresp", {31'b0, HRESP},     32'h1);
        chk("ia_err1_hrdy",  {31'b0, HREADYOUT}, 32'h0);
        chk("ia_err1_psel",  {31'b0, PSEL},      32'h0);
        tick();
        chk("ia_err2_hresp", {31'b0, HRESP},     32'h1);
        chk("ia_err2_hrdy",  {31'b0, HREADYOUT}, 32'h1);
        chk("ia_err2_psel",  {31'b0, PSEL},      32'h0);
        tick();
        chk("ia_idle_psel",  {31'b0, PSEL},      32'h0);
        chk("ia_idle_hresp", {31'b0, HRESP},     32'h0);

        // ---------------- back-to-back write then read at 0x0 ----------------
        PRDATA = 32'h1234_5678;
        addr_phase(32'h0000_0000, 1'b1, 3'b010);            // LATCH
        HWDATA = 32'h0000_0001;
        tick();                                              // SETUP
        chk("bb_w_pwdata",  PWDATA,             32'h1);
        tick();                                              // ACCESS
        tick();                                              // DONE
        chk("bb_done_hrdy", {31'b0, HREADYOUT}, 32'h1);
        addr_phase(32'h0000_0000, 1'b0, 3'b010);            // DONE+1 LATCH
        chk("bb_latch_psel", {31'b0, PSEL},     32'h0);
        chk("bb_latch_hrdy", {31'b0, HREADYOUT}, 32'h0);
        tick();                                              // DONE+2 SETUP
        chk("bb_setup_psel", {31'b0, PSEL},     32'h1);
        chk("bb_setup_pen",  {31'b0, PENABLE},  32'h0);
        chk("bb_setup_pwr",  {31'b0, PWRITE},   32'h0);
        tick();                                              // ACCESS
        tick();                                              // DONE
        chk("bb_r_hrdy",    {31'b0, HREADYOUT}, 32'h1);
        chk("bb_r_hrdata",  HRDATA,             32'h1234_5678);
        tick();

        // ---------------- reset during ACCESS ----------------
        PREADY = 1'b0;
        addr_phase(32'h0000_0008, 1'b1, 3'b010);
        HWDATA = 32'h0000_0055;
        tick();                                              // SETUP
        tick();                                              // ACCESS
        chk("rs_acc_pen",   {31'b0, PENABLE},   32'h1);
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        chk("rs_psel",      {31'b0, PSEL},      32'h0);
        chk("rs_penable",   {31'b0, PENABLE},   32'h0);
        chk("rs_hrdy",      {31'b0, HREADYOUT}, 32'h1);
        chk("rs_hresp",     {31'b0, HRESP},     32'h0);
        chk("rs_paddr",     {20'b0, PADDR},     32'h0);
        chk("rs_hrdata",    HRDATA,             32'h0);
        PREADY = 1'b1;
        tick();
        chk("rs_idle_psel", {31'b0, PSEL},      32'h0);
        // Upper address bits must be ignored: maps to PADDR 0x000.
        addr_phase(32'hABC0_0000, 1'b1, 3'b010);            // LATCH
        HWDATA = 32'h0000_0077;
        chk("rs2_latch_hrdy", {31'b0, HREADYOUT}, 32'h0);
        tick();                                              // SETUP
        chk("rs2_setup_psel", {31'b0, PSEL},    32'h1);
        chk("rs2_paddr",    {20'b0, PADDR},     32'h0);
        tick();                                              // ACCESS
        chk("rs2_acc_pen",  {31'b0, PENABLE},   32'h1);
        tick();                                              // DONE
        chk("rs2_done_hrdy", {31'b0, HREADYOUT}, 32'h1);
        chk("rs2_done_hresp", {31'b0, HRESP},   32'h0);
        chk("rs2_pwdata",   PWDATA,             32'h77);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
